// File: rtl/ram_port0_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between NREQ requesters, with in-order read return.
// Define RAM_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead of round-robin.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// Per-requester command gating: a lane's fields pass only while it holds the grant.
module ram_port0_arbiter_lane #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int MW = 8
) (
  input  logic          gnt,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          we_g,
  output logic [MW-1:0] wmask_g,
  output logic [AW-1:0] addr_g,
  output logic [DW-1:0] wdata_g
);
  assign we_g    = gnt & we;
  assign wmask_g = {MW{gnt}} & wmask;
  assign addr_g  = {AW{gnt}} & addr;
  assign wdata_g = {DW{gnt}} & wdata;
endmodule

module ram_port0_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = `ADDR_WIDTH,
  parameter int DW   = `DATA_WIDTH,
  parameter int MW   = `DATA_WIDTH/4
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*MW-1:0] req_wmask,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               cs0,
  output logic               we0,
  output logic [MW-1:0]      wmask0,
  output logic [AW-1:0]      addr0,
  output logic [DW-1:0]      din0,
  input  logic [DW-1:0]      dout0
);
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STAGES = 2;

  logic                     found;
  logic [PW-1:0]            win;
  logic [PW-1:0]            idx;
  logic [NREQ-1:0]          gnt;
  logic                     hs;
  logic                     rd_hs;

  logic [NREQ-1:0]          we_g;
  logic [NREQ-1:0][MW-1:0]  wmask_g;
  logic [NREQ-1:0][AW-1:0]  addr_g;
  logic [NREQ-1:0][DW-1:0]  wdata_g;

  logic                     sel_we;
  logic [MW-1:0]            sel_wmask;
  logic [AW-1:0]            sel_addr;
  logic [DW-1:0]            sel_wdata;

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][NREQ-1:0]  id_pipe;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr;

  // Search starts at ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0)
      ptr <= '0;
    else if (hs)
      ptr <= (int'(win) == NREQ-1) ? '0 : win + 1'b1;
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
`endif

  // Nothing is granted while reset is held, even with valid requests pending.
  always_comb begin
    gnt = '0;
    if (found && !rst0)
      gnt[win] = 1'b1;
  end

  assign hs        = found & ~rst0;
  assign req_ready = gnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    ram_port0_arbiter_lane #(.AW(AW), .DW(DW), .MW(MW)) u_lane (
      .gnt     (gnt[i]),
      .we      (req_we[i]),
      .wmask   (req_wmask[i*MW +: MW]),
      .addr    (req_addr[i*AW +: AW]),
      .wdata   (req_wdata[i*DW +: DW]),
      .we_g    (we_g[i]),
      .wmask_g (wmask_g[i]),
      .addr_g  (addr_g[i]),
      .wdata_g (wdata_g[i])
    );
  end

  // Grant is one-hot, so an OR across lanes acts as the winner mux.
  always_comb begin
    sel_we    = 1'b0;
    sel_wmask = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_we    = sel_we    | we_g[i];
      sel_wmask = sel_wmask | wmask_g[i];
      sel_addr  = sel_addr  | addr_g[i];
      sel_wdata = sel_wdata | wdata_g[i];
    end
  end

  assign rd_hs = hs & ~sel_we;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      cs0    <= 1'b0;
      we0    <= 1'b0;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
    end else if (hs) begin
      cs0    <= 1'b1;
      we0    <= sel_we;
      wmask0 <= sel_wmask;
      addr0  <= sel_addr;
      din0   <= sel_wdata;
    end else begin
      cs0 <= 1'b0;
      we0 <= 1'b0;
    end
  end

  // Stage 1 tracks the issued command, stage 2 lines up with dout0.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_hs;
      id_pipe[1]  <= rd_hs ? gnt : '0;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else if (vld_pipe[STAGES]) begin
      rsp_valid <= id_pipe[STAGES];
      rsp_rdata <= dout0;
    end else begin
      rsp_valid <= '0;
    end
  end
endmodule

// File: tb/tb_ram_port0_arbiter.sv
// Directed bench for ram_port0_arbiter with a behavioural port-0 SRAM model.
module tb_ram_port0_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MW   = DW/4;

  logic               clk0 = 1'b0;
  logic               rst0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*MW-1:0] req_wmask;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               cs0, we0;
  logic [MW-1:0]      wmask0;
  logic [AW-1:0]      addr0;
  logic [DW-1:0]      din0;
  logic [DW-1:0]      dout0;

  int vectors = 0;
  int errors  = 0;

  ram_port0_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MW(MW)) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs0(cs0), .we0(we0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0)
  );

  always #5 clk0 = ~clk0;

  // SRAM model: masked write, registered read data.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] wtmp;
  always @(posedge clk0) begin
    if (cs0) begin
      if (we0) begin
        wtmp = mem[addr0];
        for (int b = 0; b < MW; b++)
          if (wmask0[b]) wtmp[b*4 +: 4] = din0[b*4 +: 4];
        mem[addr0] <= wtmp;
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [MW-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_wmask[i*MW +: MW] = m;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [NREQ-1:0] exp_rdy;
    int              w;
    rst0      = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_wmask = '0;
    req_addr  = '0;
    req_wdata = '0;
    // all requesters valid, zero-mask writes to 0x40+i
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 1'b1, '0, AW'(8'h40 + i), 32'hDEAD_0000 + DW'(i));
    #1;
    chk("rst_ready_initial", req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ready", req_ready, 0);
    end
    chk("rst_cs0", cs0, 0);
    chk("rst_we0", we0, 0);
    chk("rst_wmask0", wmask0, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);

    // arbitration sequence with all four valid
    rst0 = 1'b0;
    #1;
    for (int j = 0; j < 8; j++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = j % NREQ;
`endif
      exp_rdy = '0;
      exp_rdy[w] = 1'b1;
      chk("arb_ready", req_ready, exp_rdy);
      tick();
      chk("arb_cs0", cs0, 1);
      chk("arb_we0_zero_mask", we0, 1);
      chk("arb_addr0", addr0, 64'(8'h40 + w));
    end
    req_valid = '0;
    #1;
    chk("idle_ready", req_ready, 0);
    tick();
    chk("idle_cs0", cs0, 0);
    chk("idle_we0", we0, 0);
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("idle_addr0_hold", addr0, 64'h40);
`else
    chk("idle_addr0_hold", addr0, 64'h43);
`endif

    // requester 2: full-mask write then read next cycle
    set_req(2, 1'b1, 1'b1, 8'hFF, 8'h10, 32'hA5A5_A5A5);
    #1;
    chk("wr_ready", req_ready, 4'b0100);
    tick();
    chk("wr_cs0", cs0, 1);
    chk("wr_we0", we0, 1);
    chk("wr_din0", din0, 32'hA5A5_A5A5);
    chk("wr_wmask0", wmask0, 8'hFF);
    set_req(2, 1'b1, 1'b0, 8'hFF, 8'h10, 32'h0);
    #1;
    chk("rd_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("rd_cs0", cs0, 1);
    chk("rd_we0", we0, 0);
    chk("rd_addr0", addr0, 8'h10);
    chk("rd_rsp_n1", rsp_valid, 0);
    tick();
    chk("rd_rsp_n2", rsp_valid, 0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 4'b0100);
    chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
    tick();
    chk("rd_rsp_done", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 32'hA5A5_A5A5);

    // partial mask: only nibble 0 written
    set_req(2, 1'b1, 1'b1, 8'h01, 8'h10, 32'hFFFF_FFFF);
    tick();
    set_req(2, 1'b1, 1'b0, 8'hFF, 8'h10, 32'h0);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("pm_rsp_valid", rsp_valid, 4'b0100);
    chk("pm_rsp_rdata", rsp_rdata, 32'hA5A5_A5AF);

    // preload two addresses through requester 0
    set_req(0, 1'b1, 1'b1, 8'hFF, 8'h20, 32'h1111_2222);
    tick();
    set_req(0, 1'b1, 1'b1, 8'hFF, 8'h30, 32'h3333_4444);
    tick();
    req_valid = '0;

    // ordering: requesters 1 and 3 back-to-back reads
    set_req(1, 1'b1, 1'b0, 8'hFF, 8'h20, 32'h0);
    set_req(3, 1'b1, 1'b0, 8'hFF, 8'h30, 32'h0);
    #1;
    chk("ord_ready_first", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("ord_ready_second", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    chk("ord_rsp_early", rsp_valid, 0);
    tick();
    chk("ord_rsp1_valid", rsp_valid, 4'b0010);
    chk("ord_rsp1_rdata", rsp_rdata, 32'h1111_2222);
    tick();
    chk("ord_rsp3_valid", rsp_valid, 4'b1000);
    chk("ord_rsp3_rdata", rsp_rdata, 32'h3333_4444);
    tick();
    chk("ord_rsp_done", rsp_valid, 0);

    // reset one cycle after a read handshake
    set_req(0, 1'b1, 1'b0, 8'hFF, 8'h20, 32'h0);
    #1;
    chk("mid_ready", req_ready, 4'b0001);
    tick();
    rst0 = 1'b1;
    set_req(1, 1'b1, 1'b0, 8'hFF, 8'h30, 32'h0);
    #1;
    chk("mid_rst_ready", req_ready, 0);
    tick();
    chk("mid_rst_cs0", cs0, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    rst0 = 1'b0;
    #1;
    chk("mid_ptr_reset", req_ready, 4'b0001);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_no_cs0", cs0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ram_port0_arbiter.md
# ram_port0_arbiter

Round-robin arbiter that shares RAM port 0 between `NREQ` requesters. Accepts read/write commands over a valid/ready handshake, drives the port-0 command signals from registers, and returns read data to the issuing requester in order. Sits between client engines and the `ram_port0_intf` instance of the SRAM macro; owns every port-0 input except `clk0`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, `` `ADDR_WIDTH ``: address width.
- `DW`, `` `DATA_WIDTH ``: data width.
- `MW`, `` `DATA_WIDTH/4 ``: write-mask width. Each mask bit enables 4 contiguous data bits.

Ports:
- `clk0` in 1: sole clock, shared with the RAM port.
- `rst0` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: command valid, one bit per requester.
- `req_ready` out NREQ: command accepted this cycle, one-hot or zero.
- `req_we` in NREQ: 1 = write, 0 = read.
- `req_wmask` in NREQ*MW: write masks, requester i at bits [i*MW +: MW].
- `req_addr` in NREQ*AW: addresses, packed the same way.
- `req_wdata` in NREQ*DW: write data, packed the same way.
- `rsp_valid` out NREQ: one-hot read-response strobe.
- `rsp_rdata` out DW: read data, shared by all requesters and qualified by `rsp_valid`.
- `cs0`, `we0` out 1: RAM chip select and write enable, active-high.
- `wmask0` out MW, `addr0` out AW, `din0` out DW: RAM command signals.
- `dout0` in DW: RAM read data. Valid the cycle after the RAM samples a read.

## Operation
- Arbitration is combinational each cycle:
  - The winner is the first requester with `req_valid` high, searching from `ptr` upward modulo NREQ.
  - `req_ready[winner]` = 1; all other `req_ready` bits = 0.
  - If no requester is valid, `req_ready` = 0.
- `ptr` is a clog2(NREQ)-bit register:
  - On each handshake it updates to (winner+1) mod NREQ.
  - Otherwise it holds.
- Requesters hold command fields stable while `req_valid` is high and `req_ready` is low.
  - `req_valid` must not depend on `req_ready`.
- Issue register: on a handshake, the winner's fields are registered into the RAM command signals.
  - `cs0` = 1 and `we0` = `req_we`; `wmask0`, `addr0` and `din0` take the winner's fields.
  - With no handshake: `cs0` = 0 and `we0` = 0; `addr0`, `din0` and `wmask0` hold their previous values.
- Read tracking uses a 2-stage shift register of {valid, one-hot id}.
  - Stage 1 loads on a read handshake.
  - Stage 2 aligns with `dout0` validity.
  - When stage 2 is valid: `rsp_rdata` <= `dout0` and `rsp_valid` <= id. Otherwise `rsp_valid` <= 0 and `rsp_rdata` holds.
- Writes produce no response.
- Writes with an all-zero mask are still issued (`cs0` = 1).
- There is no response backpressure, so the pipeline never stalls.
  - One command is issued per cycle at most.
  - Responses return strictly in issue order.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst0` is high.
  - `cs0`, `we0`, `wmask0`, `addr0`, `din0`, `rsp_valid` and `rsp_rdata` = 0.
  - `ptr` = 0 and both tracking stages are invalid.
- Handshake at the edge ending cycle N gives:
  - Cycle N+1: `cs0`/`addr0` valid.
  - Edge ending N+1: RAM samples.
  - Cycle N+2: `dout0` valid.
  - Cycle N+3: `rsp_valid` = 1.
  - Read latency is 3 cycles from acceptance to response.
- Throughput: a single continuously valid requester is accepted every cycle.
- Read-after-write to the same address on the next cycle returns the new data, because the RAM completes the write before sampling the read.
- Reset mid-operation:
  - In-flight reads are discarded.
  - `rsp_valid` = 0 from the first cycle after the reset edge.
  - No stale `cs0` is issued.
- If `rst0` and `req_valid` are high together, nothing is accepted.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, `ptr` is not implemented, and requester 0 can starve others.
  - Undefined (default): round-robin as above.
- Latency, handshake and reset behaviour are identical in both modes.

## Test plan
- Reset: hold `rst0` 3 cycles with all `req_valid` = 1 -> all outputs 0 and no `req_ready` during reset; first grant after release goes to requester 0.
- Round-robin: all 4 requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3. With `RAM_ARB_FIXED_PRIO_EN` -> eight grants to requester 0.
- Write/read:
  - Requester 2 writes 0xA5A5A5A5 to addr 0x10 with full mask, then reads 0x10 next cycle.
  - Expect `rsp_valid` = 4'b0100 exactly 3 cycles after the read handshake, with `rsp_rdata` = 0xA5A5A5A5.
- Partial mask: after the full-mask write above, write 0xFFFFFFFF with wmask bit 0 only -> readback 0xA5A5A5AF.
- Ordering: requesters 1 and 3 issue back-to-back reads of distinct preloaded addresses -> responses arrive on consecutive cycles, each with the correct id/data pair.
- Reset mid-flight: assert `rst0` one cycle after a read handshake -> no `rsp_valid` ever appears for that read.
